// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding, default width
// and the overflow helper used when SERIAL_ADDER_OVERFLOW_EN is defined.
package serial_adder_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two's-complement overflow: carry into the MSB disagrees with carry out of it.
  function automatic logic ovf_of(input logic carry_into_msb, input logic carry_out_msb);
    return carry_into_msb ^ carry_out_msb;
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit combinational full adder; the serial adder reuses a single instance
// for every bit position.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder, LSB first, one bit per clock. Defining SERIAL_ADDER_OVERFLOW_EN
// adds the ovf output (signed overflow of the completed addition).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef SERIAL_ADDER_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int              CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] s_r;
  logic [WIDTH-1:0] s_shift_s;
  logic [CNT_W-1:0] cnt_r;
  logic             carry_r;
  logic             cout_r;
  logic             busy_r;
  logic             done_r;
  logic             fa_sum_s;
  logic             fa_cout_s;
  logic             last_bit_s;

  full_adder u_full_adder (
    .a    (a_sh_r[0]),
    .b    (b_sh_r[0]),
    .cin  (carry_r),
    .s    (fa_sum_s),
    .cout (fa_cout_s)
  );

  assign last_bit_s = (cnt_r == CNT_LAST);

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_next_s = RUN;
        else       state_next_s = IDLE;
      end
      RUN: begin
        if (last_bit_s) state_next_s = DONE;
        else            state_next_s = RUN;
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // New sum bit enters at the MSB so the word is aligned after WIDTH shifts.
  always_comb begin
    s_shift_s            = s_r >> 1'b1;
    s_shift_s[WIDTH-1]   = fa_sum_s;
  end

  // State register and registered status outputs, aligned with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != IDLE);
      done_r  <= (state_next_s == DONE);
    end
  end

  // Operand capture, bit-serial datapath and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sh_r  <= {WIDTH{1'b0}};
      b_sh_r  <= {WIDTH{1'b0}};
      s_r     <= {WIDTH{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_sh_r  <= a;
            b_sh_r  <= b;
            carry_r <= cin;
            cnt_r   <= {CNT_W{1'b0}};
          end
        end
        RUN: begin
          a_sh_r  <= a_sh_r >> 1'b1;
          b_sh_r  <= b_sh_r >> 1'b1;
          s_r     <= s_shift_s;
          carry_r <= fa_cout_s;
          cnt_r   <= cnt_r + CNT_ONE;
          if (last_bit_s) cout_r <= fa_cout_s;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic ovf_r;

  // On the MSB step carry_r is the carry into the MSB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_r <= 1'b0;
    end else if (state_r == RUN && last_bit_s) begin
      ovf_r <= ovf_of(carry_r, fa_cout_s);
    end
  end

  assign ovf = ovf_r;
`endif

  assign busy = busy_r;
  assign done = done_r;
  assign s    = s_r;
  assign cout = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases, randomized operations
// against an arithmetic reference, reset abort and an exhaustive WIDTH=4 sweep.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       reset;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, s8;
  logic       start4, cin4, busy4, done4, cout4;
  logic [3:0] a4, b4, s4;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic       ovf8, ovf4;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .s(s8), .cout(cout8)
`ifdef SERIAL_ADDER_OVERFLOW_EN
    , .ovf(ovf8)
`endif
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .s(s4), .cout(cout4)
`ifdef SERIAL_ADDER_OVERFLOW_EN
    , .ovf(ovf4)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called and returns right after a falling edge. noisy scrambles start and
  // operands while the addition runs; none of it may influence the result.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                     input bit noisy, input bit hold_start, input string tag);
    logic [8:0] exp;
    int         n, sr;
    logic       exp_ovf;
    exp     = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    sr      = int'($signed(a)) + int'($signed(b)) + int'(cin);
    exp_ovf = (sr > 127) || (sr < -128);
    start8 = 1'b1; a8 = a; b8 = b; cin8 = cin;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) check({tag, "_busy"}, 64'(busy8), 64'd1);
      if (noisy) begin
        start8 = hold_start ? 1'b1 : 1'($urandom);
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      end else begin
        start8 = hold_start;
      end
    end while (!done8 && n < 40);
    check({tag, "_latency"}, 64'(n), 64'd9);
    check({tag, "_sum"}, 64'({cout8, s8}), 64'(exp));
`ifdef SERIAL_ADDER_OVERFLOW_EN
    check({tag, "_ovf"}, 64'(ovf8), 64'(exp_ovf));
`endif
    start8 = 1'b0;
    @(negedge clk);
    check({tag, "_pulse"}, 64'({busy8, done8}), 64'd0);
    check({tag, "_hold"}, 64'({cout8, s8}), 64'(exp));
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic cin,
                     output logic [4:0] got, output int n);
    start4 = 1'b1; a4 = a; b4 = b; cin4 = cin;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      start4 = 1'b0;
      a4 = 4'($urandom); b4 = 4'($urandom);
    end while (!done4 && n < 20);
    got = {cout4, s4};
    @(negedge clk);
  endtask

  initial begin
    logic [4:0] got4;
    int         n4, dones;
    reset = 1'b1;
    start8 = 1'b0; a8 = 8'd0; b8 = 8'd0; cin8 = 1'b0;
    start4 = 1'b0; a4 = 4'd0; b4 = 4'd0; cin4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_out8", 64'({busy8, done8, cout8, s8}), 64'd0);
    check("reset_out4", 64'({busy4, done4, cout4, s4}), 64'd0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
    check("reset_ovf", 64'(ovf8), 64'd0);
`endif
    reset = 1'b0;

    // First start straight after reset release, then the directed vectors.
    op8(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0, "d0f01");
    op8(8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, "dff01");
    op8(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, "d7f01");
    op8(8'h80, 8'h80, 1'b0, 1'b0, 1'b0, "d8080");

    for (int i = 0; i < 40; i++)
      op8(8'($urandom), 8'($urandom), 1'($urandom), (i % 2) == 1, 1'b0, "rand");

    // Start held high throughout: only the first operands count, one done.
    op8(8'hA5, 8'h3C, 1'b1, 1'b1, 1'b1, "hold");
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) dones++;
    end
    check("hold_extra_done", 64'(dones), 64'd0);

    // Reset in the 4th RUN cycle aborts the operation.
    start8 = 1'b1; a8 = 8'h55; b8 = 8'h66; cin8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start8 = 1'b0;
    end
    #2 reset = 1'b1;
    #1 check("abort_out", 64'({busy8, done8, cout8, s8}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) dones++;
    end
    check("abort_no_done", 64'(dones), 64'd0);
    op8(8'h55, 8'h66, 1'b1, 1'b0, 1'b0, "after_abort");

    // Exhaustive WIDTH=4 sweep.
    $display("   a  b ci | cout s");
    $display("  ---------+-------");
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++) begin
          op4(4'(a), 4'(b), 1'(c), got4, n4);
          check("w4_sum", 64'(got4), 64'(a + b + c));
          check("w4_latency", 64'(n4), 64'd5);
          if (a == b) $display("  %2h %2h  %0d |    %0d %h", a, b, c, got4[4], got4[3:0]);
        end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
